// File: rtl/float_ser_pkg.sv
// rtl/float_ser_pkg.sv - shared constants, width derivation and FSM states for the float serializer
//
// Optional feature macro: FLOAT_SER_HDR_EN (adds the HDR state for the sync byte).
// Contents:
//   SYNC_BYTE   - sync byte sent ahead of each word when the header is enabled
//   FMT_DOUBLE  - format-string constant used by float_wid()
//   float_wid() - maps the FLOAT_FMT string to a word width (32 or 64)
//   ser_state_e - serializer FSM state encoding

package float_ser_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [63:0] FMT_DOUBLE = "double";

    // Anything other than "double" is treated as single precision.
    function automatic int float_wid(input logic [63:0] fmt);
        return (fmt == FMT_DOUBLE) ? 64 : 32;
    endfunction

`ifdef FLOAT_SER_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } ser_state_e;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;
`endif

endpackage

// File: rtl/float_ser_fifo.sv
// rtl/float_ser_fifo.sv - word FIFO between the float strobe and the byte serializer
//
// Ports:
//   clk, rstn      - clock, asynchronous active-low reset
//   push_i/wdata_i - write request and data; ignored when full unless a pop happens too
//   pop_i/rdata_o  - read request; rdata_o always shows the head word
//   full_o/empty_o - occupancy flags derived from the registered count
//   count_o        - number of stored words, 0..DEPTH

module float_ser_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot in the same edge, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/float_out_serializer.sv
// rtl/float_out_serializer.sv - buffers IEEE-754 words and streams them out MSB byte first
//
// Optional feature macro: FLOAT_SER_HDR_EN (each word is preceded by SYNC_BYTE).
// Ports:
//   clk, rstn              - clock, asynchronous active-low reset
//   float_val, float_valid - word and one-cycle capture strobe from the upstream stage
//   byte_data, byte_valid  - serialized byte, held until byte_ready accepts it
//   byte_ready             - consumer handshake
//   fifo_full              - word FIFO holds FIFO_DEPTH words
//   overflow, ovf_clr      - sticky dropped-word flag and its synchronous clear

module float_out_serializer
    import float_ser_pkg::*;
#(
    parameter  logic [63:0] FLOAT_FMT  = "float",
    parameter  int          FIFO_DEPTH = 8,
    localparam int          FLOAT_WID  = float_wid(FLOAT_FMT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [FLOAT_WID-1:0] float_val,
    input  logic                 float_valid,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 fifo_full,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    localparam int NBYTES = FLOAT_WID / 8;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    ser_state_e           state_q, state_d;
    logic [FLOAT_WID-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic                 fifo_pop;
    logic                 fifo_full_int;
    logic                 fifo_empty;
    logic [FLOAT_WID-1:0] fifo_rdata;
    logic [CW-1:0]        fifo_count;

    float_ser_fifo #(
        .WIDTH (FLOAT_WID),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (float_valid),
        .wdata_i (float_val),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full_int),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign overflow  = ovf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // A new drop outranks a clear arriving in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (float_valid && fifo_full_int && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    cnt_d    = '0;
`ifdef FLOAT_SER_HDR_EN
                    state_d  = ST_HDR;
`else
                    state_d  = ST_SEND;
`endif
                end
            end
`ifdef FLOAT_SER_HDR_EN
            ST_HDR: begin
                byte_valid = 1'b1;
                byte_data  = SYNC_BYTE;
                if (byte_ready) state_d = ST_SEND;
            end
`endif
            ST_SEND: begin
                byte_valid = 1'b1;
                byte_data  = shift_q[FLOAT_WID-1 -: 8];
                if (byte_ready) begin
                    // Returning to IDLE costs one bubble cycle before the next pop.
                    if (cnt_q == CNT_W'(NBYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        shift_d = {shift_q[FLOAT_WID-9:0], 8'h00};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_float_out_serializer.sv
// tb/tb_float_out_serializer.sv - scoreboard bench for float_out_serializer

module tb_float_out_serializer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] float_val;
    logic        float_valid;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        fifo_full;
    logic        overflow;
    logic        ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;

    logic [7:0] sb[$];
    logic       stall_seen = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always #5 clk = ~clk;

    float_out_serializer #(.FLOAT_FMT("float"), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .float_val   (float_val),
        .float_valid (float_valid),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

`ifdef FLOAT_SER_HDR_EN
    localparam int NB_OUT = 5;
    logic [63:0] float_val_d;
    logic        float_valid_d;
    logic [7:0]  byte_data_d;
    logic        byte_valid_d;
    logic        byte_ready_d;
    logic        fifo_full_d;
    logic        overflow_d;
    logic [7:0]  exp_d [9];
    int          idx_d;

    float_out_serializer #(.FLOAT_FMT("double"), .FIFO_DEPTH(8)) dut_d (
        .clk         (clk),
        .rstn        (rstn),
        .float_val   (float_val_d),
        .float_valid (float_valid_d),
        .byte_data   (byte_data_d),
        .byte_valid  (byte_valid_d),
        .byte_ready  (byte_ready_d),
        .fifo_full   (fifo_full_d),
        .overflow    (overflow_d),
        .ovf_clr     (1'b0)
    );
`else
    localparam int NB_OUT = 4;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
`ifdef FLOAT_SER_HDR_EN
        sb.push_back(8'hA5);
`endif
        for (int b = 3; b >= 0; b--) sb.push_back(w[b*8 +: 8]);
    endtask

    task automatic strobe(input logic [31:0] w, input logic expect_kept);
        float_val   = w;
        float_valid = 1'b1;
        if (expect_kept) push_word(w);
        tick();
        float_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || byte_valid) && k < 600) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bytes still expected, required 0", name, sb.size());
        end
    endtask

    // Monitor: every accepted byte is compared with the scoreboard head; a stalled
    // byte must still be presented unchanged on the next cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                n_checks++;
                if (!(byte_valid === 1'b1 && byte_data === stall_data)) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%0b data=%02h required valid=1 data=%02h",
                             byte_valid, byte_data, stall_data);
                end
            end
            stall_seen = byte_valid && !byte_ready;
            stall_data = byte_data;
            if (byte_valid && byte_ready) begin
                hs_count++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h required no byte", byte_data);
                end else begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    if (byte_data !== e) begin
                        n_fail++;
                        $display("FAIL byte_data: got %02h required %02h", byte_data, e);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rstn        = 1'b0;
        float_val   = '0;
        float_valid = 1'b0;
        byte_ready  = 1'b0;
        ovf_clr     = 1'b0;
`ifdef FLOAT_SER_HDR_EN
        float_val_d   = '0;
        float_valid_d = 1'b0;
        byte_ready_d  = 1'b1;
        exp_d = '{8'hA5, 8'h40, 8'h09, 8'h21, 8'hFB, 8'h54, 8'h44, 8'h2D, 8'h18};
`endif
        tick();
        tick();
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_data", byte_data, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_overflow", overflow, 0);
        rstn = 1'b1;
        tick();

        // Single word, consumer always ready: first byte two edges after the strobe.
        byte_ready = 1'b1;
        strobe(32'h3F80_0000, 1'b1);
        check("latency_edge1", byte_valid, 0);
        tick();
        check("latency_edge2", byte_valid, 1);
        wait_drain("drain_single");

        // Consumer toggles ready; bytes must hold until accepted.
        byte_ready = 1'b0;
        strobe(32'hC049_0FDB, 1'b1);
        for (int i = 0; i < 24; i++) begin
            byte_ready = ~byte_ready;
            tick();
        end
        byte_ready = 1'b1;
        wait_drain("drain_toggle");

        // Fill: a primer word stalls in the serializer, then 9 strobes fill and overflow.
        byte_ready = 1'b0;
        strobe(32'h1234_5678, 1'b1);
        tick();
        for (int i = 1; i <= 8; i++) begin
            strobe(32'h1111_1111 * i, 1'b1);
            if (i == 7) check("not_full_after_7", fifo_full, 0);
        end
        check("full_after_8", fifo_full, 1);
        check("no_ovf_after_8", overflow, 0);
        strobe(32'h9999_9999, 1'b0);
        check("ovf_after_9", overflow, 1);
        check("still_full_after_9", fifo_full, 1);
        ovf_clr = 1'b1;
        strobe(32'hBAD0_BAD0, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_set_wins", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Release the primer; strobe lands in the IDLE cycle that pops from the full FIFO.
        byte_ready = 1'b1;
        repeat (NB_OUT) tick();
        strobe(32'hDEAD_BEEF, 1'b1);
        check("push_pop_full_stays_full", fifo_full, 1);
        check("push_pop_full_no_ovf", overflow, 0);
        wait_drain("drain_fill");
        check("empty_after_drain", fifo_full, 0);

        // Reset after the second byte of a word abandons the rest.
        base = hs_count;
        strobe(32'hCAFE_F00D, 1'b1);
        for (int k = 0; k < 50 && hs_count < base + 2; k++) @(negedge clk);
        check("mid_word_two_bytes", 32'(hs_count - base), 2);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        sb.delete();
        #1;
        check("reset_valid_low", byte_valid, 0);
        check("reset_ovf_low", overflow, 0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (12) tick();
        check("no_byte_after_reset", byte_valid, 0);

`ifdef FLOAT_SER_HDR_EN
        float_val_d   = 64'h4009_21FB_5444_2D18;
        float_valid_d = 1'b1;
        tick();
        float_valid_d = 1'b0;
        idx_d = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (byte_valid_d && byte_ready_d) begin
                if (idx_d < 9) check("double_hdr_byte", byte_data_d, exp_d[idx_d]);
                idx_d++;
            end
        end
        check("double_hdr_count", idx_d, 9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
